// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, 8 data bits via external serializer, optional parity, STOP_BITS stop bits.
// Define UART_TX_BACK2BACK_EN to allow a new frame to be accepted in the final stop cycle (no idle gap).
module uart_tx_ctrl #(
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       ser_data,
  input  logic       ser_done,
  output logic       ser_en,
  output logic [7:0] ser_p_data,
  output logic       TX_OUT,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state;
  state_t     state_nxt;
  logic       par_en_q;
  logic       par_bit_q;
  logic [1:0] stop_cnt;
  logic       last_stop;
  logic       accept;

  assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);

`ifdef UART_TX_BACK2BACK_EN
  assign accept = Data_Valid && ((state == IDLE) || last_stop);
`else
  assign accept = Data_Valid && (state == IDLE);
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame parameters are captured only at acceptance so later input changes cannot disturb the frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ser_p_data <= 8'h00;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_cnt   <= 2'd0;
    end else begin
      if (accept) begin
        ser_p_data <= P_DATA;
        par_en_q   <= PAR_EN;
        par_bit_q  <= (^P_DATA) ^ PAR_TYP;
      end
      if ((state == STOP) && !last_stop) begin
        stop_cnt <= stop_cnt + 2'd1;
      end else begin
        stop_cnt <= 2'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP: begin
        if (last_stop) begin
          state_nxt = accept ? START : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    case (state)
      START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = !ser_done;
      end
      PARITY:  TX_OUT = par_bit_q;
      default: TX_OUT = 1'b1;
    endcase
  end

  // Decoded from the state register only, so no input reaches busy combinationally.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (STOP_BITS=1 and 2) driven in parallel with
// a behavioural serializer each; expected per-cycle line/enable sequences are queued at issue time.
module tb_uart_tx_ctrl;

`ifdef UART_TX_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {
    logic       tx;
    logic       en;
    logic       last;
    logic       first;
    int         gap;
    logic [7:0] dat;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       dv;
  logic       par_en;
  logic       par_typ;
  logic [1:0] ser_data;
  logic [1:0] ser_done;
  logic [1:0] ser_en;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [7:0] spd [2];

  item_t exp_q [2][$];

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;
  int to_seen = 0;
  bit mon_en = 1'b0;
  bit fin_req = 1'b0;
  bit fin_ack = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.STOP_BITS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .ser_data(ser_data[0]), .ser_done(ser_done[0]), .ser_en(ser_en[0]), .ser_p_data(spd[0]),
    .TX_OUT(tx[0]), .busy(busy[0])
  );

  uart_tx_ctrl #(.STOP_BITS(2)) u_dut2 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .ser_data(ser_data[1]), .ser_done(ser_done[1]), .ser_en(ser_en[1]), .ser_p_data(spd[1]),
    .TX_OUT(tx[1]), .busy(busy[1])
  );

  // Behavioural serializer: loads the byte on the first enabled cycle, then presents bits LSB first.
  logic [7:0] sh  [2];
  logic [2:0] idx [2];
  logic [1:0] act;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        act[k] <= 1'b0;
        idx[k] <= 3'd0;
      end else if (ser_en[k] && !act[k]) begin
        act[k] <= 1'b1;
        idx[k] <= 3'd0;
        sh[k]  <= spd[k];
      end else if (act[k]) begin
        if (ser_done[k]) act[k] <= 1'b0;
        else if (ser_en[k]) idx[k] <= idx[k] + 3'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ser_data[k] = act[k] ? sh[k][idx[k]] : 1'b1;
      ser_done[k] = act[k] && (idx[k] == 3'd7);
    end
  end

  // Reference model: a frame is a list of line levels, one per clock.
  task automatic push_frame(input int k, input logic [7:0] d, input logic pe, input logic pt, input int gap);
    item_t it;
    int    sb;
    logic  p;
    sb = k + 1;
    p  = (($countones(d) % 2) == 1) ^ pt;
    it = '{tx: 1'b0, en: 1'b1, last: 1'b0, first: 1'b1, gap: gap, dat: d};
    exp_q[k].push_back(it);
    for (int i = 0; i < 8; i++) begin
      it = '{tx: d[i], en: (i < 7), last: 1'b0, first: 1'b0, gap: -1, dat: d};
      exp_q[k].push_back(it);
    end
    if (pe) begin
      it = '{tx: p, en: 1'b0, last: 1'b0, first: 1'b0, gap: -1, dat: d};
      exp_q[k].push_back(it);
    end
    for (int s = 0; s < sb; s++) begin
      it = '{tx: 1'b1, en: 1'b0, last: (s == sb - 1), first: 1'b0, gap: -1, dat: d};
      exp_q[k].push_back(it);
    end
  endtask

  task automatic check(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, k, a, e, $time);
    end
  endtask

  // Monitor: one sample per cycle on the falling edge.
  bit    in_frame [2];
  int    idle_run [2];
  bit    prev_rst_lo;
  item_t it_m;

  always @(negedge clk) begin
    if (mon_en) begin
      if (to_cnt != to_seen) begin
        check("wait_bound", 0, 32'(to_seen), 32'(to_cnt));
        to_seen = to_cnt;
      end
      for (int k = 0; k < 2; k++) begin
        if (prev_rst_lo) check("reset_pdata", k, 32'(spd[k]), 32'h0);
        if (busy[k] === 1'b1) begin
          check("q_nonempty", k, 32'(exp_q[k].size() > 0), 32'd1);
          if (exp_q[k].size() > 0) begin
            it_m = exp_q[k].pop_front();
            if (it_m.first) begin
              if (it_m.gap >= 0) check("idle_gap", k, 32'(idle_run[k]), 32'(it_m.gap));
              check("ser_p_data", k, 32'(spd[k]), 32'(it_m.dat));
            end
            check("tx_out", k, 32'(tx[k]), 32'(it_m.tx));
            check("ser_en", k, 32'(ser_en[k]), 32'(it_m.en));
            in_frame[k] = !it_m.last;
          end
          idle_run[k] = 0;
        end else begin
          check("frame_done", k, 32'(in_frame[k]), 32'd0);
          in_frame[k] = 1'b0;
          check("idle_line", k, {30'd0, busy[k], tx[k] & ~ser_en[k]}, 32'd1);
          idle_run[k]++;
        end
        if (!rst) begin
          exp_q[k].delete();
          in_frame[k] = 1'b0;
        end
      end
      prev_rst_lo = !rst;
      if (fin_req && !fin_ack) begin
        for (int k = 0; k < 2; k++) check("q_drained", k, 32'(exp_q[k].size()), 32'd0);
        fin_ack = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy !== 2'b00; i++) tick();
    if (busy !== 2'b00) to_cnt++;
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    wait_idle();
    p_data = d; par_en = pe; par_typ = pt; dv = 1'b1;
    for (int k = 0; k < 2; k++) push_frame(k, d, pe, pt, -1);
    tick();
    dv = 1'b0;
    p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
  endtask

  logic [7:0] rd;
  logic       rpe;
  logic       rpt;
  int         hold;

  initial begin
    rst = 1'b0; dv = 1'b1; p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst = 1'b1; dv = 1'b0;
    tick(); tick();

    start_frame(8'hA5, 1'b1, 1'b0);
    start_frame(8'h01, 1'b1, 1'b1);
    start_frame(8'h01, 1'b1, 1'b0);
    start_frame(8'hFF, 1'b0, 1'b1);

    // Request during DATA must be dropped, not queued.
    start_frame(8'h55, 1'b1, 1'b0);
    repeat (4) tick();
    p_data = 8'h3C; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (15) tick();

    // Reset in the 5th DATA cycle aborts the frame; a fresh frame follows.
    start_frame(8'hC3, 1'b1, 1'b1);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_frame(8'h96, 1'b0, 1'b0);

    // Data_Valid held across two frames per instance.
    wait_idle();
    rd = 8'($urandom); rpe = 1'($urandom); rpt = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      push_frame(k, rd, rpe, rpt, -1);
      push_frame(k, rd, rpe, rpt, B2B ? 0 : 1);
    end
    hold = 1 + 8 + int'(rpe) + 2 + 2;
    p_data = rd; par_en = rpe; par_typ = rpt; dv = 1'b1;
    repeat (hold) tick();
    dv = 1'b0;

    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_frame(8'($urandom), 1'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (3) tick();
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) tick();
    if (!fin_ack) begin
      $display("FAIL monitor_final no final sample");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
